retry_ctrl_rx: RTL and testbench

RETRY_CTRL_RX -- requirements
Module: retry_ctrl_rx

---
 rtl/retry_ctrl_rx.sv | 112 +++++++++++
 tb/tb_retry_ctrl_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/retry_ctrl_rx.sv
// retry_ctrl_rx: receive-side link-level retry control (remote retry state machine and RETRY.Ack capture)
module retry_ctrl_rx #(
   parameter int FRAME_CNT = 5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       rx_flit_valid,
   input  logic       rx_crc_ok,
   input  logic [2:0] rx_flit_type,
   input  logic [7:0] rx_req_eseq,
   input  logic [4:0] rx_num_retry,
   input  logic [4:0] rx_num_phy_reinit,
   input  logic [7:0] rx_ack_num_free_buff,
   input  logic [7:0] rx_ack_wrt_ptr,
   input  logic       tx_ack_seq_done,
   input  logic       lrsm_expect_ack,
   output logic       retry_send_ack_seq,
   output logic [2:0] rrsm_state,
   output logic [7:0] req_eseq,
   output logic [4:0] req_num_retry,
   output logic [4:0] req_num_phy_reinit,
   output logic       ack_valid,
   output logic [7:0] ack_num_free_buff,
   output logic [7:0] ack_wrt_ptr,
   output logic [4:0] ack_num_retry,
   output logic [4:0] ack_num_phy_reinit,
   output logic       spurious_ack
);
   localparam int CW = $clog2(FRAME_CNT + 1);
   localparam logic [CW-1:0] FULL = CW'(FRAME_CNT);

   typedef enum logic [2:0] {
      RRSM_IDLE         = 3'd0,
      RRSM_RETRY_LLRACK = 3'd1
   } rrsm_e;

   rrsm_e         state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          send_q, send_d;
   logic [7:0]    req_eseq_q, req_eseq_d;
   logic [4:0]    req_nr_q, req_nr_d, req_npr_q, req_npr_d;
   logic          ack_valid_q, ack_valid_d, spurious_q, spurious_d;
   logic [7:0]    ack_fb_q, ack_fb_d, ack_wp_q, ack_wp_d;
   logic [4:0]    ack_nr_q, ack_nr_d, ack_npr_q, ack_npr_d;
   logic          good, frame, qual, req_hit, ack_hit, ack_take;

   // Flit qualification, frame counting, RRSM next state and capture of Req/Ack fields
   always_comb begin
      good        = rx_flit_valid && rx_crc_ok;
      frame       = good && rx_flit_type == 3'd2;
      qual        = good && cnt_q == FULL;
      req_hit     = qual && rx_flit_type == 3'd3;
      ack_hit     = qual && rx_flit_type == 3'd4;
      ack_take    = ack_hit && lrsm_expect_ack;
      cnt_d       = !rx_flit_valid ? cnt_q : !frame ? '0 : cnt_q == FULL ? cnt_q : cnt_q + 1'b1;
      state_d     = req_hit ? RRSM_RETRY_LLRACK :
                    (state_q == RRSM_RETRY_LLRACK && tx_ack_seq_done) ? RRSM_IDLE : state_q;
      send_d      = state_d == RRSM_RETRY_LLRACK;
      req_eseq_d  = req_hit ? rx_req_eseq : req_eseq_q;
      req_nr_d    = req_hit ? rx_num_retry : req_nr_q;
      req_npr_d   = req_hit ? rx_num_phy_reinit : req_npr_q;
      ack_valid_d = ack_take;
      spurious_d  = ack_hit && !lrsm_expect_ack;
      ack_fb_d    = ack_take ? rx_ack_num_free_buff : ack_fb_q;
      ack_wp_d    = ack_take ? rx_ack_wrt_ptr : ack_wp_q;
      ack_nr_d    = ack_take ? rx_num_retry : ack_nr_q;
      ack_npr_d   = ack_take ? rx_num_phy_reinit : ack_npr_q;
   end

   // State and output registers; reset discards partial frame counts and pending ack requests
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= RRSM_IDLE;
         cnt_q       <= '0;
         send_q      <= 1'b0;
         req_eseq_q  <= '0;
         req_nr_q    <= '0;
         req_npr_q   <= '0;
         ack_valid_q <= 1'b0;
         spurious_q  <= 1'b0;
         ack_fb_q    <= '0;
         ack_wp_q    <= '0;
         ack_nr_q    <= '0;
         ack_npr_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         send_q      <= send_d;
         req_eseq_q  <= req_eseq_d;
         req_nr_q    <= req_nr_d;
         req_npr_q   <= req_npr_d;
         ack_valid_q <= ack_valid_d;
         spurious_q  <= spurious_d;
         ack_fb_q    <= ack_fb_d;
         ack_wp_q    <= ack_wp_d;
         ack_nr_q    <= ack_nr_d;
         ack_npr_q   <= ack_npr_d;
      end
   end

   assign rrsm_state         = state_q;
   assign retry_send_ack_seq = send_q;
   assign req_eseq           = req_eseq_q;
   assign req_num_retry      = req_nr_q;
   assign req_num_phy_reinit = req_npr_q;
   assign ack_valid          = ack_valid_q;
   assign spurious_ack       = spurious_q;
   assign ack_num_free_buff  = ack_fb_q;
   assign ack_wrt_ptr        = ack_wp_q;
   assign ack_num_retry      = ack_nr_q;
   assign ack_num_phy_reinit = ack_npr_q;
endmodule

// File: tb/tb_retry_ctrl_rx.sv
// tb_retry_ctrl_rx: directed vectors with an expected-output scoreboard for retry_ctrl_rx
module tb_retry_ctrl_rx;
   typedef struct packed {
      logic [2:0] st;
      logic       send;
      logic [7:0] eseq;
      logic [4:0] nr;
      logic [4:0] npr;
      logic       av;
      logic       sp;
      logic [7:0] fb;
      logic [7:0] wp;
      logic [4:0] anr;
      logic [4:0] anpr;
   } outs_t;

   logic       i_clk = 1'b0, i_rst_n = 1'b0;
   logic       rx_flit_valid = 1'b0, rx_crc_ok = 1'b0, tx_ack_seq_done = 1'b0, lrsm_expect_ack = 1'b0;
   logic [2:0] rx_flit_type = '0;
   logic [7:0] rx_req_eseq = '0, rx_ack_num_free_buff = '0, rx_ack_wrt_ptr = '0;
   logic [4:0] rx_num_retry = '0, rx_num_phy_reinit = '0;
   logic       retry_send_ack_seq, ack_valid, spurious_ack;
   logic [2:0] rrsm_state;
   logic [7:0] req_eseq, ack_num_free_buff, ack_wrt_ptr;
   logic [4:0] req_num_retry, req_num_phy_reinit, ack_num_retry, ack_num_phy_reinit;

   outs_t e = '0;
   outs_t expq[$];
   int    tagq[$];
   int    tag = 0, n_chk = 0, n_pass = 0;

   retry_ctrl_rx #(.FRAME_CNT(5)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .rx_flit_valid(rx_flit_valid), .rx_crc_ok(rx_crc_ok), .rx_flit_type(rx_flit_type),
      .rx_req_eseq(rx_req_eseq), .rx_num_retry(rx_num_retry), .rx_num_phy_reinit(rx_num_phy_reinit),
      .rx_ack_num_free_buff(rx_ack_num_free_buff), .rx_ack_wrt_ptr(rx_ack_wrt_ptr),
      .tx_ack_seq_done(tx_ack_seq_done), .lrsm_expect_ack(lrsm_expect_ack),
      .retry_send_ack_seq(retry_send_ack_seq), .rrsm_state(rrsm_state),
      .req_eseq(req_eseq), .req_num_retry(req_num_retry), .req_num_phy_reinit(req_num_phy_reinit),
      .ack_valid(ack_valid), .ack_num_free_buff(ack_num_free_buff), .ack_wrt_ptr(ack_wrt_ptr),
      .ack_num_retry(ack_num_retry), .ack_num_phy_reinit(ack_num_phy_reinit), .spurious_ack(spurious_ack)
   );

   always #5 i_clk = ~i_clk;

   function automatic outs_t actual();
      return '{rrsm_state, retry_send_ack_seq, req_eseq, req_num_retry, req_num_phy_reinit,
               ack_valid, spurious_ack, ack_num_free_buff, ack_wrt_ptr, ack_num_retry, ack_num_phy_reinit};
   endfunction

   task automatic check(input string name, input outs_t exp);
      outs_t a;
      a = actual();
      n_chk++;
      if (a === exp) n_pass++;
      else $display("FAIL %s: got st=%0d send=%0b eseq=%h nr=%0d npr=%0d av=%0b sp=%0b fb=%h wp=%h anr=%0d anpr=%0d, expected st=%0d send=%0b eseq=%h nr=%0d npr=%0d av=%0b sp=%0b fb=%h wp=%h anr=%0d anpr=%0d",
                    name, a.st, a.send, a.eseq, a.nr, a.npr, a.av, a.sp, a.fb, a.wp, a.anr, a.anpr,
                    exp.st, exp.send, exp.eseq, exp.nr, exp.npr, exp.av, exp.sp, exp.fb, exp.wp, exp.anr, exp.anpr);
   endtask

   // Monitor: after each rising edge, compare the DUT against the oldest pending expectation
   initial forever begin
      @(posedge i_clk);
      #1;
      if (expq.size() > 0) check($sformatf("step%0d", tagq.pop_front()), expq.pop_front());
   end

   task automatic drive(input logic v, input logic crc, input logic [2:0] t, input logic [7:0] es,
                        input logic [4:0] nr, input logic [4:0] npr, input logic [7:0] fb,
                        input logic [7:0] wp, input logic done);
      rx_flit_valid = v; rx_crc_ok = crc; rx_flit_type = t; rx_req_eseq = es;
      rx_num_retry = nr; rx_num_phy_reinit = npr; rx_ack_num_free_buff = fb;
      rx_ack_wrt_ptr = wp; tx_ack_seq_done = done;
      expq.push_back(e);
      tagq.push_back(tag++);
      e.av = 1'b0;
      e.sp = 1'b0;
      @(posedge i_clk);
      #2;
      rx_flit_valid = 1'b0;
      tx_ack_seq_done = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) drive(1, 1, 3'd2, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic req(input logic [7:0] es, input logic [4:0] nr, input logic [4:0] npr, input logic done);
      drive(1, 1, 3'd3, es, nr, npr, 0, 0, done);
   endtask

   task automatic ack(input logic [7:0] fb, input logic [7:0] wp, input logic [4:0] nr, input logic [4:0] npr);
      drive(1, 1, 3'd4, 0, nr, npr, fb, wp, 0);
   endtask

   task automatic idle(input logic done);
      drive(0, 0, 3'd0, 0, 0, 0, 0, 0, done);
   endtask

   initial begin
      @(posedge i_clk);
      #2;
      check("reset_state", '0);
      i_rst_n = 1'b1;
      // Qualified Req enters LLRACK, done returns to IDLE, done in IDLE ignored
      frames(5);
      e.st = 1; e.send = 1; e.eseq = 8'h3A; e.nr = 2; e.npr = 1;
      req(8'h3A, 2, 1, 0);
      e.st = 0; e.send = 0;
      idle(1);
      idle(1);
      // Unqualified Req variants are dropped
      frames(4);
      req(8'h99, 9, 9, 0);
      frames(5);
      drive(1, 1, 3'd1, 0, 0, 0, 0, 0, 0);
      req(8'h98, 8, 8, 0);
      frames(5);
      drive(1, 0, 3'd3, 8'h97, 7, 7, 0, 0, 0);
      // Saturation: 7 frames still qualify
      frames(7);
      e.st = 1; e.send = 1; e.eseq = 8'h11; e.nr = 3; e.npr = 3;
      req(8'h11, 3, 3, 0);
      e.st = 0; e.send = 0;
      idle(1);
      // Invalid cycles leave the frame count untouched
      frames(3);
      drive(0, 1, 3'd3, 8'hEE, 1, 1, 0, 0, 0);
      frames(2);
      e.st = 1; e.send = 1; e.eseq = 8'h22; e.nr = 4; e.npr = 5;
      req(8'h22, 4, 5, 0);
      e.st = 0; e.send = 0;
      idle(1);
      // CRC-bad Frame restarts the count; expected Ack accepted
      lrsm_expect_ack = 1'b1;
      frames(3);
      drive(1, 0, 3'd2, 0, 0, 0, 0, 0, 0);
      frames(5);
      e.av = 1; e.fb = 8'h20; e.wp = 8'h10; e.anr = 3; e.anpr = 4;
      ack(8'h20, 8'h10, 3, 4);
      idle(0);
      frames(2);
      ack(8'hAA, 8'hBB, 1, 1);
      // Unexpected Ack is flagged spurious, fields held
      lrsm_expect_ack = 1'b0;
      frames(5);
      e.sp = 1;
      ack(8'h77, 8'h99, 1, 1);
      idle(0);
      // Req beats tx_ack_seq_done in LLRACK; Ack works while in LLRACK
      frames(5);
      e.st = 1; e.send = 1; e.eseq = 8'h44; e.nr = 1; e.npr = 2;
      req(8'h44, 1, 2, 0);
      frames(5);
      e.eseq = 8'h55; e.nr = 6; e.npr = 7;
      req(8'h55, 6, 7, 1);
      lrsm_expect_ack = 1'b1;
      frames(5);
      e.av = 1; e.fb = 8'h0A; e.wp = 8'h0B; e.anr = 2; e.anpr = 2;
      ack(8'h0A, 8'h0B, 2, 2);
      // Mid-sequence async reset clears everything immediately
      frames(3);
      i_rst_n = 1'b0;
      #1;
      e = '0;
      check("async_reset", '0);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b1;
      frames(2);
      req(8'h66, 1, 1, 0);
      frames(5);
      e.st = 1; e.send = 1; e.eseq = 8'h77; e.nr = 5; e.npr = 6;
      req(8'h77, 5, 6, 0);
      e.st = 0; e.send = 0;
      idle(1);
      for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge i_clk);
      #3;
      if (expq.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations pending, 0 required", expq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
